// File: rtl/get_seeds_from_sibling_path_pkg.sv
// Shared constants, FSM encoding and heap-index helpers for the verifier
// seed-tree reconstruction. Constants are for parameter set L1 (LAMBDA=128).
package get_seeds_from_sibling_path_pkg;

    localparam int LAMBDA      = 128;
    localparam int SEED_SIZE   = LAMBDA;
    localparam int SALT_SIZE   = 2 * LAMBDA;
    localparam int D_HYPERCUBE = 8;
    localparam int SEED_WORDS  = SEED_SIZE / 32;
    localparam int SALT_WORDS  = SALT_SIZE / 32;
    localparam int MSG_WORDS   = SALT_WORDS + SEED_WORDS;
    localparam int PATH_WORDS  = D_HYPERCUBE * SEED_WORDS;
    localparam int NUM_LEAVES  = 2 ** D_HYPERCUBE;
    localparam int TREE_WORDS  = NUM_LEAVES * SEED_WORDS;

    localparam int SALT_AW = $clog2(SALT_WORDS);
    localparam int PATH_AW = $clog2(PATH_WORDS);
    localparam int MSG_AW  = $clog2(MSG_WORDS);
    localparam int TREE_AW = $clog2(TREE_WORDS);
    localparam int LEAF_AW = $clog2(NUM_LEAVES * SEED_WORDS);
    localparam int NODE_W  = D_HYPERCUBE + 1;
    localparam int LVL_W   = $clog2(D_HYPERCUBE + 1);
    localparam int CNT_W   = $clog2(PATH_WORDS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SCAN,
        ST_COPY,
        ST_WAIT,
        ST_RECV,
        ST_ACK,
        ST_DONE
    } state_t;

    // Level of heap node n is the index of its most significant set bit.
    function automatic logic [LVL_W-1:0] node_level(input logic [NODE_W-1:0] n);
        node_level = '0;
        for (int b = 0; b < NODE_W; b++) begin
            if (n[b]) node_level = LVL_W'(b);
        end
    endfunction

    // Ancestor of leaf i_star at level lvl (root is node 1 at level 0).
    function automatic logic [NODE_W-1:0] ancestor(input logic [D_HYPERCUBE-1:0] i_star,
                                                   input logic [LVL_W-1:0] lvl);
        ancestor = {1'b1, i_star} >> (D_HYPERCUBE - int'(lvl));
    endfunction

endpackage

// File: rtl/get_seeds_from_sibling_path_mem.sv
// Single-port RAM with registered read data (one-cycle read latency).
// Contents are never cleared.
module mem_single #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write-first is not needed: a read in the write cycle returns old data.
    always_ff @(posedge clk) begin
        if (wen) mem[addr] <= din;
        dout <= mem[addr];
    end

endmodule

// File: rtl/get_seeds_from_sibling_path.sv
// Verifier-side GGM tree reconstruction: rebuilds every leaf seed except
// leaf i_star from the sibling path, driving the shared hash core once per
// non-ancestor internal node and streaming leaf words downstream.
//
// state | meaning
// IDLE  | salt/path loads allowed, waiting for i_start
// INIT  | path levels 1..D-1 -> tree, level-D sibling leaf emitted
// SCAN  | walk node index, skipping ancestors of i_star
// COPY  | tree node -> message seed slot, then start hash
// WAIT  | waiting for the first digest word
// RECV  | accept 2*SEED_WORDS digest words into children or leaf stream
// ACK   | waiting for force_done acknowledge
// DONE  | one-cycle completion pulse
module get_seeds_from_sibling_path
    import get_seeds_from_sibling_path_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    output logic                   o_done,
    input  logic [D_HYPERCUBE-1:0] i_i_star,
    input  logic [SALT_AW-1:0]     i_salt_addr,
    input  logic                   i_salt_wen,
    input  logic [31:0]            i_salt,
    input  logic [PATH_AW-1:0]     i_path_addr,
    input  logic                   i_path_wen,
    input  logic [31:0]            i_path,
    output logic [31:0]            o_leaf_seed,
    output logic                   o_leaf_seed_valid,
    output logic [LEAF_AW-1:0]     o_leaf_seed_addr,
    output logic [31:0]            o_hash_data_in,
    input  logic [MSG_AW-1:0]      i_hash_addr,
    input  logic                   i_hash_rd_en,
    input  logic [31:0]            i_hash_data_out,
    input  logic                   i_hash_data_out_valid,
    output logic                   o_hash_data_out_ready,
    output logic [31:0]            o_hash_input_length,
    output logic [31:0]            o_hash_output_length,
    output logic                   o_hash_start,
    output logic                   o_hash_force_done,
    input  logic                   i_hash_force_done_ack
);

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [NODE_W-1:0]      node, node_nx;
    logic [D_HYPERCUBE-1:0] i_star_q, i_star_nx;
    logic                   fd_nx;
    logic                   rd_q;

    logic               msg_we, path_we, tree_we, copy_we;
    logic [MSG_AW-1:0]  msg_addr, copy_addr;
    logic [PATH_AW-1:0] path_addr, path_rd_addr;
    logic [TREE_AW-1:0] tree_addr;
    logic [31:0]        msg_din, msg_dout, path_dout, tree_din, tree_dout;

    logic [LVL_W-1:0]   lvl;
    logic               anc_hit;
    logic [NODE_W-1:0]  init_sib_anc;
    int                 init_idx, init_lvl, init_w, recv_child, recv_w;

    assign o_hash_input_length  = 32'(SALT_SIZE + SEED_SIZE);
    assign o_hash_output_length = 32'(2 * SEED_SIZE);
    assign o_hash_data_in       = rd_q ? msg_dout : '0;

    assign lvl          = node_level(node);
    assign anc_hit      = (node == ancestor(i_star_q, lvl));
    assign init_idx     = int'(cnt) - 1;
    assign init_lvl     = init_idx / SEED_WORDS + 1;
    assign init_w       = init_idx % SEED_WORDS;
    assign init_sib_anc = ancestor(i_star_q, LVL_W'(init_lvl));
    assign recv_child   = 2 * int'(node) + ((int'(cnt) >= SEED_WORDS) ? 1 : 0);
    assign recv_w       = int'(cnt) % SEED_WORDS;

    mem_single #(.WIDTH(32), .DEPTH(MSG_WORDS)) u_msg (
        .clk(i_clk), .addr(msg_addr), .wen(msg_we), .din(msg_din), .dout(msg_dout)
    );

    mem_single #(.WIDTH(32), .DEPTH(PATH_WORDS)) u_path (
        .clk(i_clk), .addr(path_addr), .wen(path_we), .din(i_path), .dout(path_dout)
    );

    mem_single #(.WIDTH(32), .DEPTH(TREE_WORDS)) u_tree (
        .clk(i_clk), .addr(tree_addr), .wen(tree_we), .din(tree_din), .dout(tree_dout)
    );

    // State, counters and the registered force_done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            node              <= '0;
            i_star_q          <= '0;
            o_hash_force_done <= 1'b0;
            rd_q              <= 1'b0;
        end else begin
            state             <= state_nx;
            cnt               <= cnt_nx;
            node              <= node_nx;
            i_star_q          <= i_star_nx;
            o_hash_force_done <= fd_nx;
            rd_q              <= i_hash_rd_en;
        end
    end

    // Buffer port steering: the hash core's message reads win over seed copies.
    always_comb begin
        msg_we   = 1'b0;
        msg_addr = MSG_AW'(i_salt_addr);
        msg_din  = i_salt;
        if (i_hash_rd_en) begin
            msg_addr = i_hash_addr;
        end else if (copy_we) begin
            msg_we   = 1'b1;
            msg_addr = copy_addr;
            msg_din  = tree_dout;
        end else if (state == ST_IDLE && i_salt_wen) begin
            msg_we = 1'b1;
        end
        path_we   = (state == ST_IDLE) && i_path_wen;
        path_addr = (state == ST_IDLE) ? i_path_addr : path_rd_addr;
    end

    // Next-state and output decode.
    always_comb begin
        state_nx              = state;
        cnt_nx                = cnt;
        node_nx               = node;
        i_star_nx             = i_star_q;
        fd_nx                 = 1'b0;
        o_done                = 1'b0;
        o_leaf_seed           = '0;
        o_leaf_seed_valid     = 1'b0;
        o_leaf_seed_addr      = '0;
        o_hash_data_out_ready = 1'b0;
        o_hash_start          = 1'b0;
        tree_we               = 1'b0;
        tree_addr             = '0;
        tree_din              = '0;
        copy_we               = 1'b0;
        copy_addr             = '0;
        path_rd_addr          = '0;
        unique case (state)
            ST_IDLE: begin
                if (i_start) begin
                    i_star_nx = i_i_star;
                    cnt_nx    = '0;
                    state_nx  = ST_INIT;
                end
            end
            ST_INIT: begin
                // Read word cnt while handling word cnt-1 returned by the RAM.
                path_rd_addr = PATH_AW'(cnt);
                cnt_nx       = cnt + CNT_W'(1);
                if (cnt != '0) begin
                    if (init_lvl < D_HYPERCUBE) begin
                        tree_we   = 1'b1;
                        tree_addr = TREE_AW'(int'({init_sib_anc[NODE_W-1:1], ~init_sib_anc[0]})
                                             * SEED_WORDS + init_w);
                        tree_din  = path_dout;
                    end else begin
                        o_leaf_seed_valid = 1'b1;
                        o_leaf_seed       = path_dout;
                        o_leaf_seed_addr  = LEAF_AW'(int'({i_star_q[D_HYPERCUBE-1:1], ~i_star_q[0]})
                                                     * SEED_WORDS + init_w);
                    end
                end
                if (cnt == CNT_W'(PATH_WORDS)) begin
                    cnt_nx   = '0;
                    node_nx  = NODE_W'(2);
                    state_nx = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (node == NODE_W'(NUM_LEAVES)) begin
                    state_nx = ST_DONE;
                end else if (anc_hit) begin
                    node_nx = node + NODE_W'(1);
                end else begin
                    cnt_nx   = '0;
                    state_nx = ST_COPY;
                end
            end
            ST_COPY: begin
                tree_addr = TREE_AW'(int'(node) * SEED_WORDS + int'(cnt));
                cnt_nx    = cnt + CNT_W'(1);
                if (cnt != '0) begin
                    copy_we   = 1'b1;
                    copy_addr = MSG_AW'(SALT_WORDS + int'(cnt) - 1);
                end
                if (cnt == CNT_W'(SEED_WORDS)) begin
                    o_hash_start = 1'b1;
                    cnt_nx       = '0;
                    state_nx     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_hash_data_out_valid) state_nx = ST_RECV;
            end
            ST_RECV: begin
                o_hash_data_out_ready = 1'b1;
                if (i_hash_data_out_valid) begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (lvl == LVL_W'(D_HYPERCUBE - 1)) begin
                        o_leaf_seed_valid = 1'b1;
                        o_leaf_seed       = i_hash_data_out;
                        o_leaf_seed_addr  = LEAF_AW'((recv_child - NUM_LEAVES) * SEED_WORDS + recv_w);
                    end else begin
                        tree_we   = 1'b1;
                        tree_addr = TREE_AW'(recv_child * SEED_WORDS + recv_w);
                        tree_din  = i_hash_data_out;
                    end
                    if (cnt == CNT_W'(2 * SEED_WORDS - 1)) begin
                        fd_nx    = 1'b1;
                        cnt_nx   = '0;
                        state_nx = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (i_hash_force_done_ack) begin
                    node_nx  = node + NODE_W'(1);
                    state_nx = ST_SCAN;
                end
            end
            ST_DONE: begin
                o_done   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_get_seeds_from_sibling_path.sv
// Bench: builds a full GGM tree in software with a stand-in hash, hands the
// DUT the sibling path, emulates the hash core on the bus and checks every
// emitted leaf word against the software tree.
module tb_get_seeds_from_sibling_path;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [7:0]  istar_in;
    logic [2:0]  salt_addr;
    logic        salt_wen;
    logic [31:0] salt_w;
    logic [4:0]  path_addr;
    logic        path_wen;
    logic [31:0] path_w;
    logic [31:0] leaf_seed;
    logic        leaf_valid;
    logic [9:0]  leaf_addr;
    logic [31:0] hash_data_in;
    logic [3:0]  hash_addr;
    logic        hash_rd_en;
    logic [31:0] hash_data_out;
    logic        hash_valid;
    logic        hash_ready;
    logic [31:0] in_len, out_len;
    logic        hash_start;
    logic        force_done;
    logic        force_ack;

    always #5 clk = ~clk;

    get_seeds_from_sibling_path dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_done(done), .i_i_star(istar_in),
        .i_salt_addr(salt_addr), .i_salt_wen(salt_wen), .i_salt(salt_w),
        .i_path_addr(path_addr), .i_path_wen(path_wen), .i_path(path_w),
        .o_leaf_seed(leaf_seed), .o_leaf_seed_valid(leaf_valid), .o_leaf_seed_addr(leaf_addr),
        .o_hash_data_in(hash_data_in), .i_hash_addr(hash_addr), .i_hash_rd_en(hash_rd_en),
        .i_hash_data_out(hash_data_out), .i_hash_data_out_valid(hash_valid),
        .o_hash_data_out_ready(hash_ready), .o_hash_input_length(in_len),
        .o_hash_output_length(out_len), .o_hash_start(hash_start),
        .o_hash_force_done(force_done), .i_hash_force_done_ack(force_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Software model of the tree.
    logic [31:0] salt_m [8];
    logic [31:0] path_m [32];
    logic [31:0] tree_m [512][4];

    function automatic logic [31:0] hfun(input logic [31:0] m [12], input int j);
        logic [31:0] acc;
        acc = 32'h9E3779B9 * (j + 1);
        for (int i = 0; i < 12; i++) begin
            acc = (acc ^ m[i]) * 32'h01000193;
            acc = acc ^ (acc >> 15);
        end
        return acc;
    endfunction

    task automatic build_model(input int star);
        logic [31:0] msg [12];
        int a;
        for (int i = 0; i < 8; i++) salt_m[i] = $urandom;
        for (int w = 0; w < 4; w++) tree_m[1][w] = $urandom;
        for (int n = 1; n < 256; n++) begin
            for (int i = 0; i < 8; i++) msg[i] = salt_m[i];
            for (int w = 0; w < 4; w++) msg[8 + w] = tree_m[n][w];
            for (int k = 0; k < 8; k++) tree_m[2 * n + k / 4][k % 4] = hfun(msg, k);
        end
        for (int l = 1; l <= 8; l++) begin
            a = (256 | star) >> (8 - l);
            for (int w = 0; w < 4; w++) path_m[(l - 1) * 4 + w] = tree_m[a ^ 1][w];
        end
    endtask

    // Leaf / event monitor.
    int cur_star = 0;
    int done_cnt, hash_starts, leaf_cnt;
    bit seen [256][4];
    int li, lw;

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (hash_start) hash_starts++;
            if (leaf_valid) begin
                li = int'(leaf_addr) / 4;
                lw = int'(leaf_addr) % 4;
                check_val("leaf_not_star", 32'(li != cur_star), 32'd1);
                check_val("leaf_data", leaf_seed, tree_m[256 + li][lw]);
                check_val("leaf_dup", 32'(seen[li][lw]), 32'd0);
                seen[li][lw] = 1'b1;
                leaf_cnt++;
            end
        end
    end

    // Hash core stand-in.
    int  core_st = 0;
    int  ri, kk, dly;
    int  ack_delay = 0;
    bit  toggle = 1'b0;
    bit  acc_s = 1'b0;
    logic [31:0] cm [12];
    logic [31:0] dg [8];

    always @(negedge clk) acc_s = hash_valid && hash_ready;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            core_st = 0; hash_rd_en = 1'b0; hash_valid = 1'b0; force_ack = 1'b0;
        end else begin
            case (core_st)
                0: if (hash_start) begin core_st = 1; ri = 0; end
                1: begin
                    if (ri > 0) cm[ri - 1] = hash_data_in;
                    if (ri < 12) begin
                        hash_addr = 4'(ri); hash_rd_en = 1'b1; ri++;
                    end else begin
                        hash_rd_en = 1'b0;
                        for (int j = 0; j < 8; j++) dg[j] = hfun(cm, j);
                        kk = 0; core_st = 2;
                    end
                end
                2: begin
                    if (acc_s) kk++;
                    if (kk == 8) begin
                        hash_valid = 1'b0;
                        if (force_done) begin dly = ack_delay; core_st = 4; end
                        else core_st = 3;
                    end else begin
                        hash_valid    = toggle ? !hash_valid : 1'b1;
                        hash_data_out = dg[kk];
                    end
                end
                3: if (force_done) begin dly = ack_delay; core_st = 4; end
                4: begin
                    check_val("ack_hold_start", 32'(hash_start), 32'd0);
                    check_val("ack_hold_ready", 32'(hash_ready), 32'd0);
                    if (dly == 0) begin force_ack = 1'b1; core_st = 5; end
                    else dly--;
                end
                5: begin force_ack = 1'b0; core_st = 0; end
                default: core_st = 0;
            endcase
        end
    end

    task automatic load_and_start(input int star);
        build_model(star);
        cur_star = star;
        done_cnt = 0; hash_starts = 0; leaf_cnt = 0;
        for (int i = 0; i < 256; i++) for (int w = 0; w < 4; w++) seen[i][w] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            salt_addr = 3'(i); salt_w = salt_m[i]; salt_wen = 1'b1;
            @(posedge clk); #1;
        end
        salt_wen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            path_addr = 5'(i); path_w = path_m[i]; path_wen = 1'b1;
            @(posedge clk); #1;
        end
        path_wen = 1'b0;
        istar_in = 8'(star); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; istar_in = ~8'(star);
    endtask

    task automatic run(input int star, input bit tg, input int dl, input bit inject);
        int cyc;
        int missing;
        bit injected;
        toggle = tg; ack_delay = dl; injected = 1'b0;
        load_and_start(star);
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            if (inject && !injected && hash_starts >= 5 && core_st == 1) begin
                start = 1'b1; istar_in = 8'(star) ^ 8'h55; injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check_val("done_in_time", 32'(cyc < 20000), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        missing = 0;
        for (int n = 0; n < 256; n++)
            for (int w = 0; w < 4; w++)
                if (n != star && !seen[n][w]) missing++;
        check_val("done_count", 32'(done_cnt), 32'd1);
        check_val("hash_count", 32'(hash_starts), 32'd247);
        check_val("leaf_words", 32'(leaf_cnt), 32'd1020);
        check_val("leaf_missing", 32'(missing), 32'd0);
    endtask

    task automatic run_abort(input int star);
        int cyc;
        int s_leaf, s_hash;
        toggle = 1'b0; ack_delay = 0;
        load_and_start(star);
        cyc = 0;
        while (!(hash_starts == 100 && hash_ready) && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("abort_reach", 32'(cyc < 20000), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_valid", 32'(leaf_valid), 32'd0);
        check_val("abort_leaf", leaf_seed, 32'd0);
        check_val("abort_addr", 32'(leaf_addr), 32'd0);
        check_val("abort_hdin", hash_data_in, 32'd0);
        check_val("abort_ready", 32'(hash_ready), 32'd0);
        check_val("abort_start", 32'(hash_start), 32'd0);
        check_val("abort_fdone", 32'(force_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_leaf = leaf_cnt; s_hash = hash_starts;
        repeat (20) @(posedge clk);
        #1;
        check_val("abort_quiet_leaf", 32'(leaf_cnt), 32'(s_leaf));
        check_val("abort_quiet_hash", 32'(hash_starts), 32'(s_hash));
        check_val("abort_quiet_done", 32'(done_cnt), 32'd0);
    endtask

    initial begin
        repeat (99000) @(posedge clk);
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; istar_in = '0;
        salt_addr = '0; salt_wen = 1'b0; salt_w = '0;
        path_addr = '0; path_wen = 1'b0; path_w = '0;
        hash_addr = '0; hash_rd_en = 1'b0; hash_data_out = '0; hash_valid = 1'b0; force_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_valid", 32'(leaf_valid), 32'd0);
        check_val("rst_addr", 32'(leaf_addr), 32'd0);
        check_val("rst_leaf", leaf_seed, 32'd0);
        check_val("rst_start", 32'(hash_start), 32'd0);
        check_val("rst_fdone", 32'(force_done), 32'd0);
        check_val("rst_ready", 32'(hash_ready), 32'd0);
        check_val("rst_hdin", hash_data_in, 32'd0);
        check_val("in_len", in_len, 32'd384);
        check_val("out_len", out_len, 32'd256);
        @(posedge clk); #1;
        rst = 1'b0;

        run(0, 1'b0, 0, 1'b0);
        run(255, 1'b1, 0, 1'b0);
        run(int'($urandom_range(1, 254)), 1'b0, 5, 1'b1);
        run_abort(int'($urandom_range(0, 255)));
        run(17, 1'b1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/get_seeds_from_sibling_path.md
Name: get_seeds_from_sibling_path

Overview:
- Verifier-side block for SDitH: reconstructs all 2^D − 1 leaf seeds of the GGM seed tree except leaf i_star, from the D-seed sibling path and the salt.
- Counterpart of the signer's sibling-path extraction. Drives the shared external hash core; each expansion hashes (salt || seed) to a 2·SEED_SIZE output holding the left and right child seeds.
- Leaf seeds stream out word-by-word with addresses to the downstream share/commit logic.

Parameters:
- PARAMETER_SET, "L1", selects LAMBDA as 128/192/256 for L1/L3/L5.
- LAMBDA, 128, security level in bits.
- SEED_SIZE, LAMBDA, seed width in bits.
- SALT_SIZE, 2*LAMBDA, salt width in bits.
- D_HYPERCUBE, 8, tree depth D; the tree has 2^D leaves.
- SEED_WORDS, SEED_SIZE/32, number of 32-bit words per seed.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start pulse; ignored unless the FSM is in IDLE
- o_done  out  1  one-cycle pulse when all leaves have been emitted
- i_i_star  in  D  hidden leaf index
- i_salt_addr  in  CLOG2(SALT_SIZE/32)  salt load address
- i_salt_wen  in  1  salt write enable
- i_salt  in  32  salt word
- i_path_addr  in  CLOG2(D*SEED_WORDS)  sibling path load address; word (l−1)*SEED_WORDS+w holds the level-l sibling, l = 1..D
- i_path_wen  in  1  path write enable
- i_path  in  32  path word
- o_leaf_seed  out  32  leaf seed word
- o_leaf_seed_valid  out  1  leaf word valid
- o_leaf_seed_addr  out  CLOG2(2^D*SEED_WORDS)  leaf_index*SEED_WORDS + word
- o_hash_data_in  out  32  message word (salt || seed) read by the hash core
- i_hash_addr  in  CLOG2((SALT_SIZE+SEED_SIZE)/32)  hash message read address
- i_hash_rd_en  in  1  hash message read enable
- i_hash_data_out  in  32  digest word
- i_hash_data_out_valid  in  1  digest word valid
- o_hash_data_out_ready  out  1  digest word accepted
- o_hash_input_length  out  32  constant SALT_SIZE+SEED_SIZE
- o_hash_output_length  out  32  constant 2*SEED_SIZE
- o_hash_start  out  1  one-cycle hash start pulse
- o_hash_force_done  out  1  one-cycle squeeze-terminate pulse
- i_hash_force_done_ack  in  1  hash core acknowledges force_done

Behaviour:
- Reset:
  - All outputs and counters go to 0.
  - FSM goes to IDLE.
  - Memory contents are not cleared.
  - Reset mid-operation aborts immediately. No further valid, start or done is issued.
- Storage:
  - MSG buffer: (SALT_SIZE+SEED_SIZE)/32 words. Salt is at words 0..SALT_SIZE/32−1; the seed slot follows.
  - PATH buffer: D*SEED_WORDS words.
  - TREE buffer: heap-indexed, node n at words n*SEED_WORDS.., n = 2..2^D−1. All buffers have 1-cycle read latency.
- Heap convention:
  - Node n has level floor(log2 n) and children 2n and 2n+1.
  - Ancestor at level l: A_l = (2^D | i_star) >> (D−l).
  - Sibling at level l: A_l ^ 1.
- FSM states and transitions:
  - IDLE: on i_start, latch i_star, then go to INIT.
  - INIT: copy PATH level l = 1..D−1 into TREE at node A_l^1. Then emit the level-D sibling leaf (i_star^1) from PATH: SEED_WORDS valid words, addr (i_star^1)*SEED_WORDS+w. Set n=2, go to SCAN.
  - SCAN:
    - If n == 2^D: go to DONE.
    - Else if n == A_level(n): n++, stay in SCAN (one cycle per skipped node).
    - Else: go to COPY.
  - COPY: read TREE node n (SEED_WORDS words) into the MSG seed slot. Then pulse o_hash_start and go to WAIT.
  - WAIT: on i_hash_data_out_valid, go to RECV.
  - RECV:
    - o_hash_data_out_ready=1. Count only cycles with valid&ready, k = 0..2*SEED_WORDS−1.
    - Word k belongs to child c = 2n + (k ≥ SEED_WORDS).
    - If level(n) < D−1: write the word into TREE node c.
    - If level(n) == D−1: drive o_leaf_seed_valid with addr (c−2^D)*SEED_WORDS + k mod SEED_WORDS, in the same cycle as the accepted word.
    - Valid gaps stall the count.
    - After the last word: pulse o_hash_force_done, go to ACK.
  - ACK: on i_hash_force_done_ack: n++, go to SCAN.
  - DONE: pulse o_done, go to IDLE.
- Totals per run:
  - Exactly 2^D−D−1 hashes (247 for D=8).
  - Exactly (2^D−1)*SEED_WORDS valid leaf words.
  - Leaf i_star is never addressed.
- Bus and buffer rules:
  - MSG read port: i_hash_rd_en has priority over internal writes. Internal writes occur only in COPY, when the hash core is idle.
  - Salt/path write ports are usable only in IDLE. Writes in other states are undefined.
  - i_start outside IDLE is ignored.

Decomposition:
- Shared sdith_pkg holds the per-set constants LAMBDA, SEED_WORDS, SALT_WORDS and D_HYPERCUBE, plus the FSM state encoding.
- Buffers instantiate the existing mem_single three times (MSG, PATH, TREE). No other sub-module.

Test Plan:
- L1, i_star=0, reference-model hash → sibling nodes 3,5,9,...,129 are loaded; leaf 1 comes from PATH; 247 hash starts; 1020 leaf words matching the software model; addr 0..3 never valid.
- i_star=255 → ancestors 3,7,...,255 are skipped; 247 hashes; leaves 0..254 match the model.
- Hash valid toggling 1-0-1 during RECV → no word lost or duplicated; leaf addresses stay contiguous.
- i_rst asserted during the 100th hash RECV → all outputs 0 next cycle; a fresh i_start with i_star=17 completes correctly.
- i_start pulsed in WAIT → ignored; exactly one o_done per run.
- i_hash_force_done_ack delayed 5 cycles → FSM holds in ACK; o_hash_start is not reissued early.
